// File: rtl/timing_fail_safe_monitor.sv
// Purpose : measures active width / line count of each video frame, flags range errors and tracks lock.
// Latency : meas_*, error flags, OK and frame_done update one cycle after the v_sync rising edge.
// Backpr. : none; free-running observer, every input cycle is sampled.
// Ports   : clock, n_reset (async active-low); enable gates the monitor (0 = IDLE, all cleared);
//           v_sync, d_en active-high timing inputs; meas_width/meas_lines = last evaluated frame;
//           width_*/Line_* range flags, no_signal_err, OK (locked), frame_done (1-cycle pulse).
module timing_fail_safe_monitor #(
  parameter int W_BITS      = 12,
  parameter int L_BITS      = 11,
  parameter int EXP_WIDTH   = 1920,
  parameter int EXP_LINES   = 1080,
  parameter int TOL         = 0,
  parameter int LOCK_FRAMES = 3,
  parameter int LOSS_FRAMES = 2,
  parameter int TIMEOUT     = 4000000
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              enable,
  input  logic              v_sync,
  input  logic              d_en,
  output logic [W_BITS-1:0] meas_width,
  output logic [L_BITS-1:0] meas_lines,
  output logic              width_High_err,
  output logic              width_Low_err,
  output logic              Line_High_err,
  output logic              Line_Low_err,
  output logic              no_signal_err,
  output logic              OK,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, CHECK, LOCKED} state_t;

  localparam int TO_BITS  = 24;
  localparam int CNT_BITS = 8;
  localparam int W_HI     = EXP_WIDTH + TOL;
  localparam int W_LO     = EXP_WIDTH - TOL;
  localparam int L_HI     = EXP_LINES + TOL;
  localparam int L_LO     = EXP_LINES - TOL;

  state_t              state_q, state_d;
  logic                vs_q, vs_d, de_q, de_d;
  logic                in_run_q, in_run_d;
  logic [W_BITS-1:0]   run_q, run_d, min_w_q, min_w_d, max_w_q, max_w_d;
  logic [W_BITS-1:0]   meas_width_q, meas_width_d;
  logic [L_BITS-1:0]   lines_q, lines_d, meas_lines_q, meas_lines_d;
  logic [TO_BITS-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_BITS-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic                w_hi_q, w_hi_d, w_lo_q, w_lo_d, l_hi_q, l_hi_d, l_lo_q, l_lo_d;
  logic                no_sig_q, no_sig_d, ok_q, ok_d, frame_done_q, frame_done_d;

  logic vs_rise, de_rise, de_fall, to_hit;
  logic e_w_hi, e_w_lo, e_l_hi, e_l_lo, e_good;

  assign vs_rise = v_sync & ~vs_q;
  assign de_rise = d_en & ~de_q;
  assign de_fall = ~d_en & de_q;

  // An empty frame has no valid minimum, so it is forced to read as too narrow and too short.
  assign e_w_hi = int'(max_w_q) > W_HI;
  assign e_w_lo = (lines_q == '0) || (int'(min_w_q) < W_LO);
  assign e_l_hi = int'(lines_q) > L_HI;
  assign e_l_lo = (lines_q == '0) || (int'(lines_q) < L_LO);
  assign e_good = ~(e_w_hi | e_w_lo | e_l_hi | e_l_lo);

  // A v_sync edge in the same cycle always wins over the timeout.
  assign to_hit = (state_q != IDLE) && !vs_rise && ((int'(to_cnt_q) + 1) >= TIMEOUT);

  always_comb begin
    state_d      = state_q;
    vs_d         = v_sync;
    de_d         = d_en;
    in_run_d     = in_run_q;
    run_d        = run_q;
    min_w_d      = min_w_q;
    max_w_d      = max_w_q;
    lines_d      = lines_q;
    to_cnt_d     = to_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    meas_width_d = meas_width_q;
    meas_lines_d = meas_lines_q;
    w_hi_d       = w_hi_q;
    w_lo_d       = w_lo_q;
    l_hi_d       = l_hi_q;
    l_lo_d       = l_lo_q;
    no_sig_d     = no_sig_q;
    frame_done_d = 1'b0;

    // A run only counts if its rising edge fell inside the current frame.
    if (de_rise) begin
      in_run_d = 1'b1;
      run_d    = W_BITS'(1);
    end else if (d_en && in_run_q && (run_q != '1)) begin
      run_d = run_q + 1'b1;
    end
    if (de_fall && in_run_q) begin
      in_run_d = 1'b0;
      run_d    = '0;
      if (run_q > max_w_q) max_w_d = run_q;
      if (run_q < min_w_q) min_w_d = run_q;
      if (lines_q != '1) lines_d = lines_q + 1'b1;
    end

    if (vs_rise)               to_cnt_d = '0;
    else if (to_cnt_q != '1)   to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      IDLE: state_d = ACQUIRE;
      ACQUIRE: begin
        // Priming edge: starts the first measured frame, nothing is evaluated.
        if (vs_rise) begin
          state_d    = CHECK;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          no_sig_d   = 1'b0;
        end
      end
      CHECK, LOCKED: begin
        if (vs_rise) begin
          frame_done_d = 1'b1;
          meas_width_d = max_w_q;
          meas_lines_d = lines_q;
          w_hi_d       = e_w_hi;
          w_lo_d       = e_w_lo;
          l_hi_d       = e_l_hi;
          l_lo_d       = e_l_lo;
          no_sig_d     = 1'b0;
          if (state_q == CHECK) begin
            if (!e_good) begin
              good_cnt_d = '0;
            end else if ((int'(good_cnt_q) + 1) >= LOCK_FRAMES) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            if (e_good) begin
              bad_cnt_d = '0;
            end else if ((int'(bad_cnt_q) + 1) >= LOSS_FRAMES) begin
              state_d    = CHECK;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every v_sync edge opens a fresh frame; a run already in progress is dropped.
    if (vs_rise) begin
      in_run_d = 1'b0;
      run_d    = '0;
      min_w_d  = '1;
      max_w_d  = '0;
      lines_d  = '0;
    end

    if (to_hit) begin
      state_d    = ACQUIRE;
      no_sig_d   = 1'b1;
      w_hi_d     = 1'b0;
      w_lo_d     = 1'b0;
      l_hi_d     = 1'b0;
      l_lo_d     = 1'b0;
      to_cnt_d   = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end

    if (!enable) begin
      state_d      = IDLE;
      in_run_d     = 1'b0;
      run_d        = '0;
      min_w_d      = '1;
      max_w_d      = '0;
      lines_d      = '0;
      to_cnt_d     = '0;
      good_cnt_d   = '0;
      bad_cnt_d    = '0;
      meas_width_d = '0;
      meas_lines_d = '0;
      w_hi_d       = 1'b0;
      w_lo_d       = 1'b0;
      l_hi_d       = 1'b0;
      l_lo_d       = 1'b0;
      no_sig_d     = 1'b0;
      frame_done_d = 1'b0;
    end

    ok_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      in_run_q     <= 1'b0;
      run_q        <= '0;
      min_w_q      <= '1;
      max_w_q      <= '0;
      lines_q      <= '0;
      to_cnt_q     <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      meas_width_q <= '0;
      meas_lines_q <= '0;
      w_hi_q       <= 1'b0;
      w_lo_q       <= 1'b0;
      l_hi_q       <= 1'b0;
      l_lo_q       <= 1'b0;
      no_sig_q     <= 1'b0;
      ok_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      in_run_q     <= in_run_d;
      run_q        <= run_d;
      min_w_q      <= min_w_d;
      max_w_q      <= max_w_d;
      lines_q      <= lines_d;
      to_cnt_q     <= to_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      meas_width_q <= meas_width_d;
      meas_lines_q <= meas_lines_d;
      w_hi_q       <= w_hi_d;
      w_lo_q       <= w_lo_d;
      l_hi_q       <= l_hi_d;
      l_lo_q       <= l_lo_d;
      no_sig_q     <= no_sig_d;
      ok_q         <= ok_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign meas_width     = meas_width_q;
  assign meas_lines     = meas_lines_q;
  assign width_High_err = w_hi_q;
  assign width_Low_err  = w_lo_q;
  assign Line_High_err  = l_hi_q;
  assign Line_Low_err   = l_lo_q;
  assign no_signal_err  = no_sig_q;
  assign OK             = ok_q;
  assign frame_done     = frame_done_q;

endmodule
